// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, token decoder states and CRC5 constants/helpers.
package usb_pkg;

  typedef enum logic [3:0] {
    PidOut   = 4'b0001,
    PidIn    = 4'b1001,
    PidSof   = 4'b0101,
    PidSetup = 4'b1101,
    PidData0 = 4'b0011,
    PidData1 = 4'b1011,
    PidData2 = 4'b0111,
    PidMdata = 4'b1111,
    PidAck   = 4'b0010,
    PidNak   = 4'b1010,
    PidStall = 4'b1110,
    PidNyet  = 4'b0110,
    PidPre   = 4'b1100,
    PidSplit = 4'b1000,
    PidPing  = 4'b0100
  } usb_pid_e;

  typedef enum logic [2:0] {
    StIdle,
    StGetPid,
    StGetB1,
    StGetB2,
    StWaitEop,
    StDiscard
  } tok_state_e;

  localparam logic [4:0] CRC5_INIT     = 5'h1F;
  // Remainder left after clocking the 11 data bits plus the inverted CRC field.
  localparam logic [4:0] CRC5_RESIDUAL = 5'h0C;
  localparam logic [4:0] CRC5_POLY     = 5'h05;

  // One byte through the CRC5 register, LSB first as on the wire.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (data[i] ^ c[4]) begin
        c = {c[3:0], 1'b0} ^ CRC5_POLY;
      end else begin
        c = {c[3:0], 1'b0};
      end
    end
    return c;
  endfunction

  function automatic logic is_token_pid(input logic [3:0] pid);
    logic tok;
    case (usb_pid_e'(pid))
      PidOut, PidIn, PidSof, PidSetup: tok = 1'b1;
      default:                         tok = 1'b0;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/usb_token_crc5.sv
// Byte-wise USB CRC5 register with synchronous init (priority) and enable.
module usb_token_crc5
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       init_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [4:0] crc_o,
  output logic [4:0] crc_next_o
);

  logic [4:0] crc_q, crc_d;

  always_comb begin
    crc_next_o = crc5_byte(crc_q, data_i);
    crc_d      = crc_q;
    if (init_i) begin
      crc_d = CRC5_INIT;
    end else if (en_i) begin
      crc_d = crc_next_o;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q <= CRC5_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_token_decoder.sv
// USB token packet decoder: checks PID, gathers ADDR/ENDP, verifies CRC5, pulses result.
module usb_token_decoder
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_sop,
  input  logic       rx_eop,
  input  logic       rx_err,
  output logic       tok_valid,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  output logic       pid_err,
  output logic       crc_err,
  output logic       len_err,
  output logic       busy
);

  tok_state_e state_q, state_d, st_byte;
  logic [3:0] pid_q, pid_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] endp_q, endp_d;
  logic [3:0] tok_pid_q, tok_pid_d;
  logic [6:0] tok_addr_q, tok_addr_d;
  logic [3:0] tok_endp_q, tok_endp_d;
  logic       tok_valid_q, tok_valid_d;
  logic       pid_err_q, pid_err_d;
  logic       crc_err_q, crc_err_d;
  logic       len_err_q, len_err_d;
  logic       busy_q, busy_d;

  logic       crc_init, crc_en;
  logic [4:0] crc_q, crc_next, crc_cur;

  usb_token_crc5 u_crc5 (
    .clk        (clk),
    .n_rst      (n_rst),
    .init_i     (crc_init),
    .en_i       (crc_en),
    .data_i     (rx_data),
    .crc_o      (crc_q),
    .crc_next_o (crc_next)
  );

  always_comb begin
    state_d     = state_q;
    st_byte     = state_q;
    pid_d       = pid_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    tok_pid_d   = tok_pid_q;
    tok_addr_d  = tok_addr_q;
    tok_endp_d  = tok_endp_q;
    tok_valid_d = 1'b0;
    pid_err_d   = 1'b0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    crc_cur     = crc_q;

    if (rx_sop) begin
      state_d  = StGetPid;
      crc_init = 1'b1;
    end else if (rx_err && (state_q != StIdle)) begin
      state_d = StDiscard;
    end else begin
      // A byte arriving with eop is consumed first; eop then acts on the resulting state.
      if (rx_valid) begin
        unique case (state_q)
          StGetPid: begin
            if (rx_data[7:4] != ~rx_data[3:0]) begin
              pid_err_d = 1'b1;
              st_byte   = StDiscard;
            end else if (is_token_pid(rx_data[3:0])) begin
              pid_d   = rx_data[3:0];
              st_byte = StGetB1;
            end else begin
              st_byte = StDiscard;
            end
          end
          StGetB1: begin
            addr_d    = rx_data[6:0];
            endp_d[0] = rx_data[7];
            crc_en    = 1'b1;
            st_byte   = StGetB2;
          end
          StGetB2: begin
            endp_d[3:1] = rx_data[2:0];
            crc_en      = 1'b1;
            st_byte     = StWaitEop;
          end
          StWaitEop: begin
            len_err_d = 1'b1;
            st_byte   = StDiscard;
          end
          default: ;
        endcase
      end

      crc_cur = crc_en ? crc_next : crc_q;
      state_d = st_byte;

      if (rx_eop) begin
        unique case (st_byte)
          StGetPid, StGetB1, StGetB2: begin
            len_err_d = 1'b1;
            state_d   = StIdle;
          end
          StWaitEop: begin
            if (crc_cur == CRC5_RESIDUAL) begin
              tok_valid_d = 1'b1;
              tok_pid_d   = pid_d;
              tok_addr_d  = addr_d;
              tok_endp_d  = endp_d;
            end else begin
              crc_err_d = 1'b1;
            end
            state_d = StIdle;
          end
          StDiscard: state_d = StIdle;
          default: ;
        endcase
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      pid_q       <= '0;
      addr_q      <= '0;
      endp_q      <= '0;
      tok_pid_q   <= '0;
      tok_addr_q  <= '0;
      tok_endp_q  <= '0;
      tok_valid_q <= 1'b0;
      pid_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      addr_q      <= addr_d;
      endp_q      <= endp_d;
      tok_pid_q   <= tok_pid_d;
      tok_addr_q  <= tok_addr_d;
      tok_endp_q  <= tok_endp_d;
      tok_valid_q <= tok_valid_d;
      pid_err_q   <= pid_err_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      busy_q      <= busy_d;
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_pid   = tok_pid_q;
  assign tok_addr  = tok_addr_q;
  assign tok_endp  = tok_endp_q;
  assign pid_err   = pid_err_q;
  assign crc_err   = crc_err_q;
  assign len_err   = len_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_usb_token_decoder.sv
// Directed and randomized packet bench for usb_token_decoder with a packet-level outcome model.
module tb_usb_token_decoder;

  logic       clk;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sop, rx_eop, rx_err;
  logic       tok_valid, pid_err, crc_err, len_err, busy;
  logic [3:0] tok_pid, tok_endp;
  logic [6:0] tok_addr;

  usb_token_decoder dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sop    (rx_sop),
    .rx_eop    (rx_eop),
    .rx_err    (rx_err),
    .tok_valid (tok_valid),
    .tok_pid   (tok_pid),
    .tok_addr  (tok_addr),
    .tok_endp  (tok_endp),
    .pid_err   (pid_err),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sop;
    logic       valid;
    logic       eop;
    logic       err;
    logic [7:0] data;
  } step_t;

  localparam int KNone = 0;
  localparam int KTok  = 1;
  localparam int KPid  = 2;
  localparam int KCrc  = 3;
  localparam int KLen  = 4;

  int vectors = 0;
  int fails   = 0;

  // Packet description consumed by run_packet.
  logic [7:0] pb[$];
  int         err_pos;
  bit         merged;
  bit         gaps;

  // Last good token as the model sees it.
  logic [3:0] m_pid;
  logic [6:0] m_addr;
  logic [3:0] m_endp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic step_t mk(input logic sop, input logic valid, input logic eop,
                               input logic err, input logic [7:0] d);
    step_t s;
    s.sop = sop; s.valid = valid; s.eop = eop; s.err = err; s.data = d;
    return s;
  endfunction

  task automatic drive(input step_t s);
    rx_sop   = s.sop;
    rx_valid = s.valid;
    rx_eop   = s.eop;
    rx_err   = s.err;
    rx_data  = s.data;
    @(posedge clk);
    #1;
    rx_sop   = 1'b0;
    rx_valid = 1'b0;
    rx_eop   = 1'b0;
    rx_err   = 1'b0;
    rx_data  = 8'h00;
  endtask

  function automatic bit m_is_token(input logic [3:0] p);
    return (p == 4'h1) || (p == 4'h9) || (p == 4'h5) || (p == 4'hD);
  endfunction

  // CRC field (b2[7:3]) a sender would transmit for the 11 bits {endp, addr}.
  function automatic logic [4:0] m_crc_field(input logic [10:0] bits);
    logic [4:0] r;
    logic [4:0] f;
    logic       fb;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = bits[i] ^ r[4];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    r = ~r;
    for (int j = 0; j < 5; j++) f[j] = r[4 - j];
    return f;
  endfunction

  task automatic run_packet(input string name);
    step_t q[$];
    int    bidx[6];
    int    eidx, n, n_eff, kind, trig;
    logic [10:0] bits;
    n = pb.size();
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int i = 0; i < n; i++) begin
      if (i == err_pos) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
      if (gaps && $urandom_range(0, 1) == 1) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
      bidx[i] = q.size();
      q.push_back(mk(1'b0, 1'b1, (merged && i == n - 1), 1'b0, pb[i]));
    end
    if (merged && n > 0) begin
      eidx = bidx[n - 1];
    end else begin
      if (gaps && $urandom_range(0, 1) == 1) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
      eidx = q.size();
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
    end

    n_eff = (err_pos >= 0) ? err_pos : n;
    kind  = KNone;
    trig  = -1;
    if (n_eff >= 1) begin
      if (pb[0][7:4] != ~pb[0][3:0]) begin
        kind = KPid; trig = bidx[0];
      end else if (m_is_token(pb[0][3:0])) begin
        if (n_eff >= 4) begin
          kind = KLen; trig = bidx[3];
        end else if (err_pos < 0) begin
          trig = eidx;
          if (n == 3) begin
            bits = {pb[2][2:0], pb[1]};
            kind = (pb[2][7:3] == m_crc_field(bits)) ? KTok : KCrc;
          end else begin
            kind = KLen;
          end
        end
      end
    end else if (err_pos < 0) begin
      kind = KLen; trig = eidx;
    end
    if (kind == KTok) begin
      m_pid  = pb[0][3:0];
      m_addr = pb[1][6:0];
      m_endp = {pb[2][2:0], pb[1][7]};
    end

    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      chk({name, "/tok_valid"}, tok_valid, (kind == KTok && i == trig));
      chk({name, "/pid_err"}, pid_err, (kind == KPid && i == trig));
      chk({name, "/crc_err"}, crc_err, (kind == KCrc && i == trig));
      chk({name, "/len_err"}, len_err, (kind == KLen && i == trig));
      if (i == 0) chk({name, "/busy_sop"}, busy, 1);
    end
    chk({name, "/busy_eop"}, busy, 0);
    chk({name, "/tok_pid"}, tok_pid, m_pid);
    chk({name, "/tok_addr"}, tok_addr, m_addr);
    chk({name, "/tok_endp"}, tok_endp, m_endp);
  endtask

  task automatic set_pkt(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int ep, input bit mg);
    pb.delete();
    if (n > 0) pb.push_back(b0);
    if (n > 1) pb.push_back(b1);
    if (n > 2) pb.push_back(b2);
    err_pos = ep;
    merged  = mg;
    gaps    = 1'b0;
  endtask

  initial begin
    logic [7:0] tok_pids[4];
    logic [7:0] oth_pids[3];
    logic [7:0] b0, b1, b2;
    int         n, r;
    tok_pids = '{8'hE1, 8'h69, 8'hA5, 8'h2D};
    oth_pids = '{8'hC3, 8'h4B, 8'hD2};
    m_pid = '0; m_addr = '0; m_endp = '0;

    n_rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_sop = 1'b0;
    rx_eop = 1'b0; rx_err = 1'b0;
    #12;
    chk("reset_outputs", {tok_valid, pid_err, crc_err, len_err, busy, tok_pid, tok_addr, tok_endp},
        0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    set_pkt(3, 8'h2D, 8'h00, 8'h10, -1, 1'b0); run_packet("setup_good");
    set_pkt(3, 8'h2D, 8'h00, 8'h11, -1, 1'b0); run_packet("setup_badcrc");
    set_pkt(1, 8'h2C, 8'h00, 8'h00, -1, 1'b0); run_packet("bad_pid");
    set_pkt(2, 8'h2D, 8'h00, 8'h00, -1, 1'b0); run_packet("short_tok");
    set_pkt(3, 8'hC3, 8'h00, 8'h00, -1, 1'b0); run_packet("data0_pkt");
    set_pkt(0, 8'h00, 8'h00, 8'h00, -1, 1'b0); run_packet("empty_pkt");
    set_pkt(3, 8'h2D, 8'h00, 8'h10, 1, 1'b0);  run_packet("rx_err_drop");
    set_pkt(3, 8'h2D, 8'h00, 8'h10, -1, 1'b0); run_packet("after_err");
    b1 = 8'hA3;
    b2 = {m_crc_field({3'b101, b1}), 3'b101};
    set_pkt(3, 8'hA5, b1, b2, -1, 1'b1);       run_packet("sof_merged_eop");
    pb.push_back(8'h00); pb.push_back(8'h00);  err_pos = -1; merged = 1'b0;
    run_packet("long_tok");

    // Reset while a good token is mid-flight.
    drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    drive(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h2D));
    drive(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
    #2 n_rst = 1'b0;
    #1;
    chk("async_reset", {tok_valid, pid_err, crc_err, len_err, busy, tok_pid, tok_addr, tok_endp},
        0);
    m_pid = '0; m_addr = '0; m_endp = '0;
    @(negedge clk);
    n_rst = 1'b1;
    drive(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h10));
    chk("post_reset_byte", {tok_valid, pid_err, crc_err, len_err, busy}, 0);
    drive(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
    chk("post_reset_eop", {tok_valid, pid_err, crc_err, len_err, busy}, 0);

    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      b0 = tok_pids[$urandom_range(0, 3)];
      else if (r < 8) b0 = oth_pids[$urandom_range(0, 2)];
      else            b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      if ($urandom_range(0, 9) < 7) b2[7:3] = m_crc_field({b2[2:0], b1});
      case ($urandom_range(0, 7))
        0, 1, 2, 3: n = 3;
        4:          n = 1;
        5:          n = 2;
        6:          n = 4 + $urandom_range(0, 1);
        default:    n = 0;
      endcase
      pb.delete();
      for (int i = 0; i < n; i++) begin
        pb.push_back((i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : 8'($urandom));
      end
      merged  = (n > 0) && ($urandom_range(0, 9) < 3);
      err_pos = ((n > 0) && ($urandom_range(0, 99) < 15)) ? $urandom_range(0, n - 1) : -1;
      gaps    = 1'($urandom_range(0, 1));
      run_packet($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
